// File: rtl/pool_engine_if.sv
// pool_engine_if: streaming pixel-in / pooled-pixel-out bundle for pool_engine.
// The master side drives raster-ordered pixels; the slave side returns pooled pixels.
interface pool_engine_if #(
  parameter int CH     = 4,
  parameter int N_DATA = 32
);
  logic                 data_in_vld;
  logic [CH*N_DATA-1:0] data_in;
  logic                 mode;
  logic [CH*N_DATA-1:0] data_out;
  logic                 data_out_vld;
  logic                 data_out_end;

  modport master (
    output data_in_vld, data_in, mode,
    input  data_out, data_out_vld, data_out_end
  );

  modport slave (
    input  data_in_vld, data_in, mode,
    output data_out, data_out_vld, data_out_end
  );
endinterface

// File: rtl/pool_engine.sv
// pool_engine: streaming KxK / stride-K pooling over a raster-ordered feature map,
// CH lanes in parallel, signed samples. Pixels beyond the last whole window in
// either direction are consumed and dropped. Optional average mode is built only
// when the macro POOL_AVG_EN is defined; otherwise mode is ignored and only the
// max datapath exists.
module pool_engine #(
  parameter int FM_ROW = 12,
  parameter int FM_COL = 12,
  parameter int K      = 2,
  parameter int CH     = 4,
  parameter int N_DATA = 32
) (
  input logic          clk,
  input logic          rst,
  pool_engine_if.slave bus
);
  localparam int LOGK     = $clog2(K);
  localparam int OUT_COLS = FM_COL / K;
  localparam int OUT_ROWS = FM_ROW / K;
  localparam int USE_COLS = OUT_COLS * K;
  localparam int USE_ROWS = OUT_ROWS * K;
  localparam int CW       = $clog2(FM_COL + 1);
  localparam int RW       = $clog2(FM_ROW + 1);
  localparam int OCW      = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
`ifdef POOL_AVG_EN
  localparam int ACC_W    = N_DATA + 2 * LOGK;
`else
  localparam int ACC_W    = N_DATA;
`endif
  localparam logic [LOGK-1:0] KLAST = LOGK'(K - 1);

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [LOGK-1:0] kc;
  logic [LOGK-1:0] kr;
  logic [OCW-1:0]  oc;
  logic            keep;
  logic            beat;
  logic            win_done;
  logic            map_last;
  logic            cur_mode;

  logic signed [ACC_W-1:0] h_acc    [CH];
  logic signed [ACC_W-1:0] line_buf [OUT_COLS][CH];
  logic signed [ACC_W-1:0] sample   [CH];
  logic signed [ACC_W-1:0] h_next   [CH];
  logic signed [ACC_W-1:0] v_next   [CH];

  logic [CH*N_DATA-1:0] out_data;
  logic                 out_vld;
  logic                 out_end;

  function automatic logic signed [ACC_W-1:0] combine(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input logic                    avg
  );
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  // Average divides by K*K with an arithmetic shift, i.e. floor toward minus infinity.
  function automatic logic [N_DATA-1:0] to_sample(
    input logic signed [ACC_W-1:0] v,
    input logic                    avg
  );
    logic signed [ACC_W-1:0] s;
    s = avg ? (v >>> (2 * LOGK)) : v;
    return N_DATA'(s);
  endfunction

  assign kc       = col[LOGK-1:0];
  assign kr       = row[LOGK-1:0];
  assign oc       = OCW'(col >> LOGK);
  assign keep     = (col < CW'(USE_COLS)) && (row < RW'(USE_ROWS));
  assign beat     = bus.data_in_vld && keep;
  assign win_done = beat && (kc == KLAST) && (kr == KLAST);
  assign map_last = (row == RW'(USE_ROWS - 1)) && (col == CW'(USE_COLS - 1));

`ifdef POOL_AVG_EN
  logic first_beat;
  logic mode_q;
  assign first_beat = (col == '0) && (row == '0);
  assign cur_mode   = first_beat ? bus.mode : mode_q;

  // Capture the combine mode on pixel (0,0) so it holds for the whole map.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (bus.data_in_vld && first_beat) begin
      mode_q <= bus.mode;
    end
  end
`else
  assign cur_mode = 1'b0;
`endif

  // Raster position counters; every valid beat advances them, discarded edge pixels included.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.data_in_vld) begin
      if (col == CW'(FM_COL - 1)) begin
        col <= '0;
        row <= (row == RW'(FM_ROW - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Per-lane horizontal result of this beat and its vertical combination with the line buffer.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sample[c] = ACC_W'($signed(bus.data_in[c*N_DATA +: N_DATA]));
      h_next[c] = (kc == '0) ? sample[c] : combine(h_acc[c], sample[c], cur_mode);
      v_next[c] = combine(line_buf[oc][c], h_next[c], cur_mode);
    end
  end

  // Accumulator and line-buffer updates; the first window row overwrites, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && beat) begin
      for (int c = 0; c < CH; c++) begin
        h_acc[c] <= h_next[c];
      end
      if ((kc == KLAST) && (kr != KLAST)) begin
        for (int c = 0; c < CH; c++) begin
          line_buf[oc][c] <= (kr == '0) ? h_next[c] : v_next[c];
        end
      end
    end
  end

  // Register the finished window one cycle after its completing beat; strobes are single-cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_vld  <= 1'b0;
      out_end  <= 1'b0;
    end else begin
      out_vld <= win_done;
      out_end <= win_done && map_last;
      if (win_done) begin
        for (int c = 0; c < CH; c++) begin
          out_data[c*N_DATA +: N_DATA] <= to_sample(v_next[c], cur_mode);
        end
      end
    end
  end

  assign bus.data_out     = out_data;
  assign bus.data_out_vld = out_vld;
  assign bus.data_out_end = out_end;
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed bench for pool_engine. A whole-map model computes each
// pooled pixel straight from the stored input window and predicts the strobe cycle;
// a negedge compare process checks both DUTs (12x12 and 13x13) every cycle.
module tb_pool_engine;
  localparam int K  = 2;
  localparam int CH = 4;
  localparam int NB = 32;
  localparam int W  = CH * NB;
`ifdef POOL_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  pool_engine_if #(.CH(CH), .N_DATA(NB)) bus0 ();
  pool_engine_if #(.CH(CH), .N_DATA(NB)) bus1 ();

  pool_engine #(.FM_ROW(12), .FM_COL(12), .K(K), .CH(CH), .N_DATA(NB)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pool_engine #(.FM_ROW(13), .FM_COL(13), .K(K), .CH(CH), .N_DATA(NB)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    bit           last;
    int           due;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  int   px [2][13][13][CH];
  int   mr [2];
  int   mc [2];
  bit   mmode [2];

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_strobe [2];
  int           n_end    [2];
  logic [W-1:0] first_data [2];
  int           second_l0 [2];
  int           last_l0   [2];

  task automatic check_lit(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] d;
    for (int l = 0; l < CH; l++) d[l*NB +: NB] = v;
    return d;
  endfunction

  // Model: store each pixel; when a beat closes a whole window, pool that window directly.
  task automatic model_beat(input int d, input logic [W-1:0] data, input bit m);
    int     r, c, fm, mx, v;
    longint s, q;
    exp_t   e;
    fm = (d == 0) ? 12 : 13;
    r  = mr[d];
    c  = mc[d];
    if (r == 0 && c == 0) mmode[d] = m & AVG_EN;
    for (int l = 0; l < CH; l++) px[d][r][c][l] = $signed(data[l*NB +: NB]);
    if ((r % K == K-1) && (c % K == K-1) && (r < (fm/K)*K) && (c < (fm/K)*K)) begin
      e.data = '0;
      for (int l = 0; l < CH; l++) begin
        s  = 0;
        mx = px[d][r][c][l];
        for (int dr = 0; dr < K; dr++) begin
          for (int dc = 0; dc < K; dc++) begin
            v = px[d][r-dr][c-dc][l];
            s += v;
            if (v > mx) mx = v;
          end
        end
        if (mmode[d]) begin
          q = s / (K*K);
          if ((s % (K*K) != 0) && (s < 0)) q--;
          e.data[l*NB +: NB] = q[NB-1:0];
        end else begin
          e.data[l*NB +: NB] = mx;
        end
      end
      e.last = (r == (fm/K)*K-1) && (c == (fm/K)*K-1);
      e.due  = cyc + 1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (c == fm-1) begin
      c = 0;
      r = (r == fm-1) ? 0 : r + 1;
    end else begin
      c++;
    end
    mr[d] = r;
    mc[d] = c;
  endtask

  task automatic applyStimulus(input int d, input bit v, input logic [W-1:0] data, input bit m);
    @(negedge clk);
    if (d == 0) begin
      bus0.data_in_vld = v; bus0.data_in = data; bus0.mode = m;
    end else begin
      bus1.data_in_vld = v; bus1.data_in = data; bus1.mode = m;
    end
    if (v) model_beat(d, data, m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus0.data_in_vld = 1'b0;
      bus1.data_in_vld = 1'b0;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus0.data_in_vld = 1'b0;
    bus1.data_in_vld = 1'b0;
    for (int d = 0; d < 2; d++) begin mr[d] = 0; mc[d] = 0; end
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      n_strobe[d] = 0; n_end[d] = 0; first_data[d] = '0; second_l0[d] = 0; last_l0[d] = 0;
    end
  endtask

  // Ramp of nb beats, lane value i+1; optional mode flip after beat toggle_at and gaps every third cycle.
  task automatic sendRamp(input int d, input int nb, input bit m0, input int toggle_at, input bit gaps);
    int i, t;
    bit m;
    i = 0;
    t = 0;
    while (i < nb) begin
      if (gaps && (t % 3 == 2)) begin
        applyStimulus(d, 1'b0, '0, m0);
      end else begin
        m = (toggle_at >= 0 && i >= toggle_at) ? ~m0 : m0;
        applyStimulus(d, 1'b1, splat(i + 1), m);
        i++;
      end
      t++;
    end
  endtask

  // Per-cycle comparison of one DUT against the head of its expectation queue.
  task automatic checkOutput(input int d, input logic vld, input logic [W-1:0] data, input logic last);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (vld === 1'b1 || last === 1'b1) begin
      if (qs == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stray_strobe dut%0d: got vld=%b end=%b at cycle %0d, required no strobe", d, vld, last, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_lit($sformatf("strobe_vld dut%0d", d), longint'(vld === 1'b1), 1);
        check_lit($sformatf("strobe_cycle dut%0d", d), cyc, e.due);
        check_vec($sformatf("data dut%0d", d), data, e.data);
        check_lit($sformatf("end dut%0d", d), longint'(last === 1'b1), longint'(e.last));
        n_strobe[d]++;
        if (last === 1'b1) n_end[d]++;
        if (n_strobe[d] == 1) first_data[d] = data;
        if (n_strobe[d] == 2) second_l0[d] = $signed(data[NB-1:0]);
        last_l0[d] = $signed(data[NB-1:0]);
      end
    end else if (qs > 0) begin
      if (d == 0) e = q0[0];
      else        e = q1[0];
      if (e.due <= cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missing_strobe dut%0d: got none at cycle %0d, required strobe at cycle %0d", d, cyc, e.due);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, bus0.data_out_vld, bus0.data_out, bus0.data_out_end);
    checkOutput(1, bus1.data_out_vld, bus1.data_out, bus1.data_out_end);
  end

  initial begin
    logic [W-1:0] d;
    int v;
    bus0.data_in_vld = 1'b0; bus0.data_in = '0; bus0.mode = 1'b0;
    bus1.data_in_vld = 1'b0; bus1.data_in = '0; bus1.mode = 1'b0;
    for (int i = 0; i < 2; i++) begin mr[i] = 0; mc[i] = 0; mmode[i] = 1'b0; end
    clear_stats();

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    check_vec("reset data_out", bus0.data_out, '0);
    check_lit("reset data_out_vld", bus0.data_out_vld, 0);
    check_lit("reset data_out_end", bus0.data_out_end, 0);
    check_lit("reset dut1 data_out_vld", bus1.data_out_vld, 0);
    rst = 1'b0;

    $display("[TB] ramp, continuous valid, max");
    clear_stats();
    sendRamp(0, 144, 1'b0, -1, 1'b0);
    idle(4);
    check_lit("ramp strobes", n_strobe[0], 36);
    check_lit("ramp first", $signed(first_data[0][NB-1:0]), 14);
    check_lit("ramp second", second_l0[0], 16);
    check_lit("ramp last", last_l0[0], 144);
    check_lit("ramp end count", n_end[0], 1);

    $display("[TB] ramp with gaps every third cycle");
    clear_stats();
    sendRamp(0, 144, ~AVG_EN, -1, 1'b1);
    idle(4);
    check_lit("gap strobes", n_strobe[0], 36);
    check_lit("gap first", $signed(first_data[0][NB-1:0]), 14);
    check_lit("gap second", second_l0[0], 16);
    check_lit("gap last", last_l0[0], 144);
    check_lit("gap end count", n_end[0], 1);

    $display("[TB] signed compare and lane independence");
    clear_stats();
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        for (int l = 0; l < CH; l++) begin
          v = -5 - l;
          if (l == 2 && r == 1 && c == 1) v = -1;
          d[l*NB +: NB] = v;
        end
        applyStimulus(0, 1'b1, d, 1'b0);
      end
    end
    idle(4);
    check_lit("signed lane0", $signed(first_data[0][0*NB +: NB]), -5);
    check_lit("signed lane1", $signed(first_data[0][1*NB +: NB]), -6);
    check_lit("signed lane2", $signed(first_data[0][2*NB +: NB]), -1);
    check_lit("signed lane3", $signed(first_data[0][3*NB +: NB]), -8);

`ifdef POOL_AVG_EN
    $display("[TB] average mode");
    clear_stats();
    sendRamp(0, 144, 1'b1, 10, 1'b0);
    idle(4);
    check_lit("avg ramp first", $signed(first_data[0][NB-1:0]), 7);
    check_lit("avg ramp strobes", n_strobe[0], 36);
    clear_stats();
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        applyStimulus(0, 1'b1, splat((r == 0 && c == 0) ? -1 : -2), 1'b1);
      end
    end
    idle(4);
    check_lit("avg negative floor", $signed(first_data[0][NB-1:0]), -2);
    clear_stats();
    sendRamp(0, 144, 1'b0, 5, 1'b0);
    idle(4);
    check_lit("mode toggle ignored", $signed(first_data[0][NB-1:0]), 14);
`endif

    $display("[TB] reset mid-map then full ramp");
    sendRamp(0, 50, 1'b0, -1, 1'b0);
    idle(2);
    pulse_reset(2);
    clear_stats();
    sendRamp(0, 144, 1'b0, -1, 1'b0);
    idle(4);
    check_lit("post-reset strobes", n_strobe[0], 36);
    check_lit("post-reset first", $signed(first_data[0][NB-1:0]), 14);

    $display("[TB] two maps back to back");
    clear_stats();
    sendRamp(0, 288, 1'b0, -1, 1'b0);
    idle(4);
    check_lit("b2b strobes", n_strobe[0], 72);
    check_lit("b2b end count", n_end[0], 2);

    $display("[TB] 13x13 map, floor of edge pixels");
    clear_stats();
    sendRamp(1, 169, 1'b0, -1, 1'b0);
    idle(4);
    check_lit("13x13 strobes", n_strobe[1], 36);
    check_lit("13x13 end count", n_end[1], 1);
    check_lit("13x13 first", $signed(first_data[1][NB-1:0]), 15);
    check_lit("13x13 last", last_l0[1], 155);

    check_lit("dut0 pending expectations", q0.size(), 0);
    check_lit("dut1 pending expectations", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
